// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if
//   Bundle of signals between the 5-stage pipeline and its hazard/sequencing
//   controller.
//   master : the pipeline side. It drives the stage status and sees the
//            freeze/flush controls.
//   slave  : the controller (pipe_hazard_ctrl).
//   Inputs : id_*, exe_*, mem_*, branch_taken.
//   Outputs: freeze_pc, freeze_if_reg, flush_if_reg, flush_id_reg,
//            freeze_pipe, mem_ready, fsm_state, stall_cycles, flush_count.
//   There is no valid/ready handshake here. Every signal is level-sampled on
//   each rising clock edge. mem_ready is the only pulse: it is high for
//   exactly one cycle, on the cycle the pipeline may advance past a memory
//   access.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src_1;
    logic [3:0]       id_src_2;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             mem_req;
    logic             branch_taken;
    logic             freeze_pc;
    logic             freeze_if_reg;
    logic             flush_if_reg;
    logic             flush_id_reg;
    logic             freeze_pipe;
    logic             mem_ready;
    logic [1:0]       fsm_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_src_1, id_src_2, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, mem_req, branch_taken,
        input  freeze_pc, freeze_if_reg, flush_if_reg, flush_id_reg,
               freeze_pipe, mem_ready, fsm_state, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_src_1, id_src_2, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, mem_req, branch_taken,
        output freeze_pc, freeze_if_reg, flush_if_reg, flush_id_reg,
               freeze_pipe, mem_ready, fsm_state, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage ARM core. It combines three sources
//   into the freeze and flush controls for the PC, the IF/ID register and the
//   ID/EX register:
//     - RAW hazards,
//     - taken branches,
//     - a multi-cycle SRAM access FSM.
//
//   Ports:
//     clk  core clock. All state changes on the rising edge.
//     rst  synchronous, active-high reset.
//     bus  pipe_hazard_if.slave. It carries the stage status in and the
//          freeze/flush controls, fsm_state and the perf counters out.
//
//   Parameters:
//     SRAM_WAIT  total cycles of one data-memory access (>=1).
//     CNT_W      width of the saturating counters. It must match the CNT_W
//                of the interface instance.
//
//   Build option:
//     PIPE_FWD_EN  Define this when a forwarding unit is present. Only a
//                  load-use case against EXE then stalls.
module pipe_hazard_ctrl #(
    parameter int SRAM_WAIT = 5,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  bus
);
    localparam int CW = $clog2(SRAM_WAIT) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam bit MULTI = (SRAM_WAIT > 1);
    localparam logic [CW-1:0] CNT_LOAD = MULTI ? CW'(SRAM_WAIT - 2) : '0;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic m_exe, m_mem, hazard, freeze_pipe_c, mem_ready_c, go;

    // cnt holds the number of freeze cycles left in WAIT, counting the
    // current cycle. The IDLE cycle that accepts the request is already a
    // freeze cycle, so WAIT starts at SRAM_WAIT-2. The FSM leaves WAIT when
    // cnt reaches 1. This gives SRAM_WAIT-1 freeze cycles in total, and the
    // access completes in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_req && MULTI) begin
                        cnt   <= CNT_LOAD;
                        state <= (SRAM_WAIT == 2) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                // mem_req is still high here for the same instruction on its
                // way out. Ignore it and start any new access from IDLE.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_exe = (bus.id_src_1 == bus.exe_dest) ||
                (bus.id_two_src && (bus.id_src_2 == bus.exe_dest));
        m_mem = (bus.id_src_1 == bus.mem_dest) ||
                (bus.id_two_src && (bus.id_src_2 == bus.mem_dest));
`ifdef PIPE_FWD_EN
        // With forwarding, only a load result that is not yet available
        // forces a stall.
        hazard = bus.id_valid && bus.exe_wb_en && bus.exe_mem_r_en && m_exe;
`else
        hazard = bus.id_valid &&
                 ((bus.exe_wb_en && m_exe) || (bus.mem_wb_en && m_mem));
`endif
        freeze_pipe_c = !rst && (((state == S_IDLE) && bus.mem_req && MULTI) ||
                                 (state == S_WAIT));
        mem_ready_c   = !rst && ((state == S_DONE) ||
                                 ((state == S_IDLE) && bus.mem_req && !MULTI));
        // A memory freeze masks branch and hazard. They are evaluated again
        // once the freeze releases, because their inputs are held meanwhile.
        go = !rst && !freeze_pipe_c;
    end

    // A taken branch squashes the instruction in ID, so that instruction's
    // hazard is moot.
    assign bus.freeze_pipe   = freeze_pipe_c;
    assign bus.mem_ready     = mem_ready_c;
    assign bus.flush_if_reg  = go && bus.branch_taken;
    assign bus.flush_id_reg  = go && (bus.branch_taken || hazard);
    assign bus.freeze_pc     = go && !bus.branch_taken && hazard;
    assign bus.freeze_if_reg = go && !bus.branch_taken && hazard;
    assign bus.fsm_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (bus.freeze_pc && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (bus.flush_if_reg && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(16)) bus ();
    pipe_hazard_if #(.CNT_W(4))  bus2 ();

    pipe_hazard_ctrl #(.SRAM_WAIT(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pipe_hazard_ctrl #(.SRAM_WAIT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic       ewb;
        logic       emr;
        logic [3:0] md;
        logic       mwb;
        logic       br;
        logic       hz_nf;   // expected hazard without forwarding
        logic       hz_fw;   // expected hazard with forwarding
    } vec_t;

    vec_t vt[14];
    int n_vec  = 0;
    int n_miss = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr();
        bus.id_valid = 0; bus.id_src_1 = 0; bus.id_src_2 = 0; bus.id_two_src = 0;
        bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.mem_dest = 0; bus.mem_wb_en = 0; bus.mem_req = 0; bus.branch_taken = 0;
        bus2.id_valid = 0; bus2.id_src_1 = 0; bus2.id_src_2 = 0; bus2.id_two_src = 0;
        bus2.exe_dest = 0; bus2.exe_wb_en = 0; bus2.exe_mem_r_en = 0;
        bus2.mem_dest = 0; bus2.mem_wb_en = 0; bus2.mem_req = 0; bus2.branch_taken = 0;
    endtask

    task automatic apply_vec(input vec_t x);
        bus.id_valid = x.v; bus.id_src_1 = x.s1; bus.id_src_2 = x.s2; bus.id_two_src = x.two;
        bus.exe_dest = x.ed; bus.exe_wb_en = x.ewb; bus.exe_mem_r_en = x.emr;
        bus.mem_dest = x.md; bus.mem_wb_en = x.mwb; bus.branch_taken = x.br;
    endtask

    // Stage status that creates an EXE RAW hazard on r3.
    task automatic set_hazard();
        bus.id_valid = 1; bus.id_src_1 = 4'd3; bus.exe_dest = 4'd3;
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
    endtask

    task automatic chk_ctrl(input string tag, input logic fpc, input logic fif,
                            input logic fid, input logic fpipe, input logic rdy);
        chk({tag, " freeze_pc"},     {31'd0, bus.freeze_pc},     {31'd0, fpc});
        chk({tag, " freeze_if_reg"}, {31'd0, bus.freeze_if_reg}, {31'd0, fpc});
        chk({tag, " flush_if_reg"},  {31'd0, bus.flush_if_reg},  {31'd0, fif});
        chk({tag, " flush_id_reg"},  {31'd0, bus.flush_id_reg},  {31'd0, fid});
        chk({tag, " freeze_pipe"},   {31'd0, bus.freeze_pipe},   {31'd0, fpipe});
        chk({tag, " mem_ready"},     {31'd0, bus.mem_ready},     {31'd0, rdy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st_pat[5];
        int base_stall;
        int base_flush;
        int waited;
        logic hz;

        st_pat = '{0, 1, 1, 1, 2};
        //          v  s1 s2 two ed ewb emr md mwb br nf fw
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0};
        vt[2]  = '{1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1};
        vt[3]  = '{1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{1, 5, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0};
        vt[5]  = '{1, 5, 7, 1, 7, 1, 0, 0, 0, 0, 1, 0};
        vt[6]  = '{1, 5, 7, 1, 7, 1, 1, 0, 0, 0, 1, 1};
        vt[7]  = '{1, 9, 0, 0, 2, 1, 1, 9, 1, 0, 1, 0};
        vt[8]  = '{1, 9, 0, 0, 2, 1, 1, 9, 0, 0, 0, 0};
        vt[9]  = '{0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0};
        vt[10] = '{1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 1, 1};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[12] = '{1, 1, 4, 1, 2, 1, 1, 4, 1, 0, 1, 0};
        vt[13] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

        // Reset: controls are forced low even with hazard, branch and mem_req active.
        clr();
        rst = 1;
        cyc(); cyc();
        set_hazard(); bus.branch_taken = 1; bus.mem_req = 1;
        #1;
        chk_ctrl("reset", 0, 0, 0, 0, 0);
        chk("reset fsm_state", {30'd0, bus.fsm_state}, 0);
        chk("reset stall_cycles", {16'd0, bus.stall_cycles}, 0);
        chk("reset flush_count", {16'd0, bus.flush_count}, 0);
        cyc();
        clr();
        rst = 0;

        // Combinational hazard and branch vectors, with the FSM idle.
        for (int i = 0; i < 14; i++) begin
            apply_vec(vt[i]);
            hz = FWD ? vt[i].hz_fw : vt[i].hz_nf;
            #1;
            chk_ctrl($sformatf("vec%0d", i), hz & ~vt[i].br, vt[i].br,
                     vt[i].br | hz, 0, 0);
            exp_stall += int'(hz & ~vt[i].br);
            exp_flush += int'(vt[i].br);
            cyc();
            chk($sformatf("vec%0d stall_cycles", i), {16'd0, bus.stall_cycles}, exp_stall);
            chk($sformatf("vec%0d flush_count", i), {16'd0, bus.flush_count}, exp_flush);
        end
        clr();
        cyc();

        // SRAM access: two back-to-back accesses. Each freezes for 4 cycles,
        // then mem_ready pulses while the FSM is in DONE.
        bus.mem_req = 1;
        for (int k = 0; k < 11; k++) begin
            if (k == 10) bus.mem_req = 0;
            #1;
            if (k < 10) begin
                chk($sformatf("mem k%0d fsm_state", k), {30'd0, bus.fsm_state}, st_pat[k % 5]);
                chk($sformatf("mem k%0d freeze_pipe", k), {31'd0, bus.freeze_pipe},
                    (k % 5 == 4) ? 0 : 1);
                chk($sformatf("mem k%0d mem_ready", k), {31'd0, bus.mem_ready},
                    (k % 5 == 4) ? 1 : 0);
            end else begin
                chk("mem end fsm_state", {30'd0, bus.fsm_state}, 0);
                chk_ctrl("mem end", 0, 0, 0, 0, 0);
            end
            cyc();
        end

        // Branch and hazard during the freeze are masked. They act on the DONE cycle.
        base_stall = int'(bus.stall_cycles);
        base_flush = int'(bus.flush_count);
        bus.mem_req = 1; set_hazard(); bus.branch_taken = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 4) chk_ctrl($sformatf("frz k%0d", k), 0, 0, 0, 1, 0);
            else       chk_ctrl("frz release", 0, 1, 1, 0, 1);
            cyc();
        end
        clr();
        chk("frz flush_count", {16'd0, bus.flush_count}, base_flush + 1);
        chk("frz stall_cycles", {16'd0, bus.stall_cycles}, base_stall);
        cyc();

        // Reset in the middle of an access, at the second WAIT cycle.
        bus.mem_req = 1;
        cyc(); cyc();
        rst = 1;
        #1;
        chk("rst mid fsm_state", {30'd0, bus.fsm_state}, 1);
        chk_ctrl("rst mid", 0, 0, 0, 0, 0);
        cyc();
        chk("rst after fsm_state", {30'd0, bus.fsm_state}, 0);
        chk("rst after stall_cycles", {16'd0, bus.stall_cycles}, 0);
        chk("rst after flush_count", {16'd0, bus.flush_count}, 0);
        chk_ctrl("rst after", 0, 0, 0, 0, 0);
        rst = 0;
        #1;
        chk("rerequest freeze_pipe", {31'd0, bus.freeze_pipe}, 1);
        waited = 0;
        while (!bus.mem_ready && waited < 20) begin
            cyc(); #1;
            waited++;
        end
        chk("rerequest cycles to mem_ready", waited, 4);
        bus.mem_req = 0;
        cyc();

        // SRAM_WAIT=1: mem_ready is immediate and there is no freeze.
        bus2.mem_req = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("w1 k%0d mem_ready", k), {31'd0, bus2.mem_ready}, 1);
            chk($sformatf("w1 k%0d freeze_pipe", k), {31'd0, bus2.freeze_pipe}, 0);
            chk($sformatf("w1 k%0d fsm_state", k), {30'd0, bus2.fsm_state}, 0);
            cyc();
        end
        bus2.mem_req = 0;

        // Counter saturation on the 4-bit instance.
        bus2.id_valid = 1; bus2.id_src_1 = 4'd3; bus2.exe_dest = 4'd3; bus2.exe_wb_en = 1;
        bus2.exe_mem_r_en = 1;
        repeat (20) cyc();
        chk("sat stall_cycles", {28'd0, bus2.stall_cycles}, 32'hf);
        chk("sat flush_count before", {28'd0, bus2.flush_count}, 0);
        clr();
        bus2.branch_taken = 1;
        repeat (20) cyc();
        chk("sat flush_count", {28'd0, bus2.flush_count}, 32'hf);
        chk("sat stall_cycles held", {28'd0, bus2.stall_cycles}, 32'hf);
        clr();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
